// File: rtl/csum_pkg.sv
// Shared types for the AXI-Stream checksum checker: checksum word, FSM states
// and the per-packet status record.
package csum_pkg;

    localparam int CSUM_W = 32;

    typedef logic [CSUM_W-1:0] csum_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } csum_state_t;

    typedef struct packed {
        logic  ok;
        csum_t calc;
        csum_t rx;
    } csum_stat_t;

endpackage

// File: rtl/csum_beat_sum.sv
// Combinational checksum of one stream beat: the DATA_W/32 words are summed
// modulo 2^32, with every byte whose keep bit is 0 counted as zero.
module csum_beat_sum
    import csum_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] keep_i,
    output csum_t               sum_o
);

    localparam int NWORDS = DATA_W / CSUM_W;

    // Mask each word byte-by-byte, then accumulate; overflow wraps naturally.
    always_comb begin
        csum_t word;
        // NOTE: every variable written here gets a value before any branch or loop, so no latch can be inferred.
        sum_o = '0;
        word  = '0;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                word[8*b +: 8] = data_i[CSUM_W*w + 8*b +: 8] & {8{keep_i[4*w + b]}};
            end
            sum_o = sum_o + word;
        end
    end

endmodule

// File: rtl/axis_csum_check.sv
// AXI-Stream RX checksum checker. The final (tlast) beat of each input packet
// is a trailer whose low 32 bits carry the expected checksum; the payload is
// forwarded through a one-beat holding register with the trailer stripped,
// and a one-cycle status pulse plus packet/error counters report the result.
// Optional build macro CSUM_ERR_FLAG_EN adds m_axis_tuser, an error flag on
// the last output beat of a mismatching packet.
module axis_csum_check
    import csum_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int CNT_W  = 32
) (
    input  logic                aclk,
    input  logic                areset,

    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic [ID_W-1:0]     s_axis_tid,
    input  logic                s_axis_tlast,

    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic [ID_W-1:0]     m_axis_tid,
    output logic                m_axis_tlast,
`ifdef CSUM_ERR_FLAG_EN
    output logic                m_axis_tuser,
`endif

    output logic                stat_valid,
    output logic                stat_ok,
    output logic [CSUM_W-1:0]   stat_csum_calc,
    output logic [CSUM_W-1:0]   stat_csum_rx,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int KEEP_W = DATA_W / 8;

    csum_state_t         state_q;
    logic [DATA_W-1:0]   hold_data_q;
    logic [KEEP_W-1:0]   hold_keep_q;
    logic [ID_W-1:0]     hold_id_q;
    csum_t               acc_q, acc_d;
    csum_stat_t          stat_q;
    logic                stat_valid_q;
    logic [CNT_W-1:0]    pkt_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic  s_ready;
    logic  m_valid;
    logic  payload_acc;
    logic  trailer_acc;
    csum_t beat_sum;
    csum_t rx_csum;
    logic  csum_ok;

    csum_beat_sum #(.DATA_W(DATA_W)) u_beat_sum (
        .data_i (s_axis_tdata),
        .keep_i (s_axis_tkeep),
        .sum_o  (beat_sum)
    );

    assign rx_csum     = s_axis_tdata[CSUM_W-1:0];
    assign csum_ok     = (acc_q == rx_csum);
    assign payload_acc = s_axis_tvalid & s_ready & ~s_axis_tlast;
    assign trailer_acc = s_axis_tvalid & s_ready &  s_axis_tlast;

    // Handshake decode: a held beat may leave only when the next payload beat
    // arrives, so in HOLD the output valid and input ready are tied together.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        if (!areset) begin
            case (state_q)
                IDLE:  s_ready = 1'b1;
                HOLD: begin
                    s_ready = s_axis_tlast | m_axis_tready;
                    m_valid = s_axis_tvalid & ~s_axis_tlast;
                end
                FLUSH: m_valid = 1'b1;
                default: begin
                    s_ready = 1'b0;
                    m_valid = 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = hold_data_q;
    assign m_axis_tkeep  = hold_keep_q;
    assign m_axis_tid    = hold_id_q;
    assign m_axis_tlast  = (state_q == FLUSH);

    // FSM and one-beat holding register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            // NOTE: the hold register is a single beat, not a memory array, so clearing it on reset is cheap and keeps outputs at 0.
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_id_q   <= '0;
        end else begin
            if (payload_acc) begin
                hold_data_q <= s_axis_tdata;
                hold_keep_q <= s_axis_tkeep;
                hold_id_q   <= s_axis_tid;
            end
            case (state_q)
                IDLE:    if (payload_acc) state_q <= HOLD;
                HOLD:    if (trailer_acc) state_q <= FLUSH;
                FLUSH:   if (m_axis_tready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Running checksum: add each payload beat, restart at the trailer.
    always_comb begin
        acc_d = acc_q;
        if (trailer_acc) begin
            acc_d = '0;
        end else if (payload_acc) begin
            acc_d = acc_q + beat_sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            acc_q <= acc_d;
        end
    end

    // Status record, one-cycle pulse and counters, updated at trailer acceptance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_q       <= '0;
            stat_valid_q <= 1'b0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            stat_valid_q <= trailer_acc;
            if (trailer_acc) begin
                stat_q    <= '{ok: csum_ok, calc: acc_q, rx: rx_csum};
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                if (!csum_ok && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign stat_valid     = stat_valid_q;
    assign stat_ok        = stat_q.ok;
    assign stat_csum_calc = stat_q.calc;
    assign stat_csum_rx   = stat_q.rx;
    assign pkt_cnt        = pkt_cnt_q;
    assign err_cnt        = err_cnt_q;

`ifdef CSUM_ERR_FLAG_EN
    logic tuser_q;

    // Error flag: captured when the trailer closes a packet with payload,
    // dropped once the flagged last beat has been taken.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tuser_q <= 1'b0;
        end else if (trailer_acc && (state_q == HOLD)) begin
            tuser_q <= ~csum_ok;
        end else if ((state_q == FLUSH) && m_axis_tready) begin
            tuser_q <= 1'b0;
        end
    end

    assign m_axis_tuser = tuser_q;
`endif

endmodule

// File: tb/tb_axis_csum_check.sv
// Self-checking bench for axis_csum_check: directed packets, random
// back-to-back traffic with random backpressure, and reset mid-packet.
// Expected beats and status come from a behavioural packet model.
module tb_axis_csum_check;

    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;
    localparam int ID_W   = 6;
    localparam int CNT_W  = 32;
    localparam int NW     = DATA_W / 32;

`ifdef CSUM_ERR_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic [ID_W-1:0]   id;
        logic              last;
        logic              user;
    } beat_t;

    typedef struct {
        logic        ok;
        logic [31:0] calc;
        logic [31:0] rx;
    } stat_t;

    logic                aclk = 1'b0;
    logic                areset;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [KEEP_W-1:0]   s_axis_tkeep;
    logic [ID_W-1:0]     s_axis_tid;
    logic                s_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready = 1'b0;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [KEEP_W-1:0]   m_axis_tkeep;
    logic [ID_W-1:0]     m_axis_tid;
    logic                m_axis_tlast;
`ifdef CSUM_ERR_FLAG_EN
    logic                m_axis_tuser;
`endif
    logic                stat_valid;
    logic                stat_ok;
    logic [31:0]         stat_csum_calc;
    logic [31:0]         stat_csum_rx;
    logic [CNT_W-1:0]    pkt_cnt;
    logic [CNT_W-1:0]    err_cnt;

    axis_csum_check #(.DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tlast   (m_axis_tlast),
`ifdef CSUM_ERR_FLAG_EN
        .m_axis_tuser   (m_axis_tuser),
`endif
        .stat_valid     (stat_valid),
        .stat_ok        (stat_ok),
        .stat_csum_calc (stat_csum_calc),
        .stat_csum_rx   (stat_csum_rx),
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    bit rdy_rand = 1'b0;

    beat_t exp_beats[$];
    beat_t obs_beats[$];
    stat_t exp_stat[$];
    stat_t obs_stat[$];
    int unsigned exp_pkt = 0;
    int unsigned exp_err = 0;

    logic [DATA_W-1:0] pb_d [16];
    logic [KEEP_W-1:0] pb_k [16];

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: always 1, or a fair coin each cycle.
    always @(posedge aclk) begin
        #1;
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: inputs are stable from posedge+1 to the next posedge, so a
    // handshake seen here is the one the next edge will complete.
    always @(negedge aclk) begin
        beat_t b;
        stat_t s;
        if (!areset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                b.d    = m_axis_tdata;
                b.k    = m_axis_tkeep;
                b.id   = m_axis_tid;
                b.last = m_axis_tlast;
`ifdef CSUM_ERR_FLAG_EN
                b.user = m_axis_tuser;
`else
                b.user = 1'b0;
`endif
                obs_beats.push_back(b);
            end
            if (stat_valid) begin
                s.ok   = stat_ok;
                s.calc = stat_csum_calc;
                s.rx   = stat_csum_rx;
                obs_stat.push_back(s);
            end
        end
    end

    // Reference checksum: each word is rebuilt from its kept bytes, words are added mod 2^32.
    function automatic logic [31:0] model_sum(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
        logic [31:0] s = 0;
        for (int w = 0; w < NW; w++) begin
            logic [31:0] word = 0;
            for (int b = 0; b < 4; b++) begin
                if (k[4*w + b]) word = word + (32'(d[32*w + 8*b +: 8]) << (8*b));
            end
            s = s + word;
        end
        return s;
    endfunction

    // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input logic [ID_W-1:0] id, input logic last);
        bit acc = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tid    = id;
        s_axis_tlast  = last;
        for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                acc = 1'b1;
                break;
            end
        end
        check("beat_accepted", 640'(acc), 640'(1));
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // Send nb payload beats from pb_d/pb_k, then a trailer carrying rx; record the model's expectations.
    task automatic send_pkt(input int nb, input logic [31:0] rx, input logic [ID_W-1:0] id);
        logic [31:0] sum = 0;
        stat_t s;
        beat_t b;
        logic [DATA_W-1:0] tr;
        for (int i = 0; i < nb; i++) sum = sum + model_sum(pb_d[i], pb_k[i]);
        s.ok = (sum == rx);
        s.calc = sum;
        s.rx = rx;
        exp_stat.push_back(s);
        exp_pkt++;
        if (!s.ok && exp_err != 32'hFFFF_FFFF) exp_err++;
        for (int i = 0; i < nb; i++) begin
            b.d = pb_d[i];
            b.k = pb_k[i];
            b.id = id;
            b.last = (i == nb - 1);
            b.user = FLAG_EN && b.last && !s.ok;
            exp_beats.push_back(b);
        end
        for (int i = 0; i < nb; i++) send_beat(pb_d[i], pb_k[i], id, 1'b0);
        for (int w = 0; w < NW; w++) tr[32*w +: 32] = $urandom;
        tr[31:0] = rx;
        send_beat(tr, {$urandom, $urandom}, id, 1'b1);
    endtask

    // Wait (bounded) for the DUT to produce everything expected, then compare and clear.
    task automatic drain_and_compare(input string tag);
        for (int t = 0; t < 2000; t++) begin
            if (obs_beats.size() >= exp_beats.size() && obs_stat.size() >= exp_stat.size()) break;
            @(posedge aclk);
            #1;
        end
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        check({tag, "_beat_count"}, 640'(obs_beats.size()), 640'(exp_beats.size()));
        check({tag, "_stat_count"}, 640'(obs_stat.size()), 640'(exp_stat.size()));
        for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
            check({tag, "_beat"},
                  640'({obs_beats[i].d, obs_beats[i].k, obs_beats[i].id, obs_beats[i].last, obs_beats[i].user}),
                  640'({exp_beats[i].d, exp_beats[i].k, exp_beats[i].id, exp_beats[i].last, exp_beats[i].user}));
        end
        for (int i = 0; i < exp_stat.size() && i < obs_stat.size(); i++) begin
            check({tag, "_stat"},
                  640'({obs_stat[i].ok, obs_stat[i].calc, obs_stat[i].rx}),
                  640'({exp_stat[i].ok, exp_stat[i].calc, exp_stat[i].rx}));
        end
        check({tag, "_pkt_cnt"}, 640'(pkt_cnt), 640'(exp_pkt));
        check({tag, "_err_cnt"}, 640'(err_cnt), 640'(exp_err));
        exp_beats.delete();
        obs_beats.delete();
        exp_stat.delete();
        obs_stat.delete();
    endtask

    // One-cycle reset pulse starting at posedge+1.
    task automatic pulse_reset();
        areset = 1'b1;
        @(negedge aclk);
        check("tready_in_reset", 640'(s_axis_tready), 640'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_beats.delete();
        obs_beats.delete();
        exp_stat.delete();
        obs_stat.delete();
        exp_pkt = 0;
        exp_err = 0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [31:0] sum;
        int nb;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tid    = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("tready_in_reset", 640'(s_axis_tready), 640'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_tready", 640'(s_axis_tready), 640'(1));
        check("rst_m_tvalid", 640'(m_axis_tvalid), 640'(0));
        check("rst_stat_valid", 640'(stat_valid), 640'(0));
        check("rst_outputs", 640'({m_axis_tdata, stat_ok, stat_csum_calc, stat_csum_rx}), 640'(0));
        check("rst_counters", 640'({pkt_cnt, err_cnt}), 640'(0));
        @(posedge aclk);
        #1;

        // 1: three full beats of all-ones words, correct trailer.
        for (int w = 0; w < NW; w++) d[32*w +: 32] = 32'd1;
        for (int i = 0; i < 3; i++) begin
            pb_d[i] = d;
            pb_k[i] = '1;
        end
        send_pkt(3, 32'h30, 6'h05);
        drain_and_compare("t1_good");

        // 2: same payload, wrong trailer.
        send_pkt(3, 32'h31, 6'h0A);
        drain_and_compare("t2_bad");

        // 3: single beat, only the low four bytes kept.
        d = '1;
        d[31:0] = 32'h1234_5678;
        pb_d[0] = d;
        pb_k[0] = KEEP_W'(16'h000F);
        send_pkt(1, 32'h1234_5678, 6'h11);
        drain_and_compare("t3_keep");

        // 4: trailer-only packet, then a wrapping word sum.
        send_pkt(0, 32'h0, 6'h00);
        drain_and_compare("t4_empty");
        d = '0;
        d[31:0]  = 32'hFFFF_FFFF;
        d[63:32] = 32'h0000_0002;
        pb_d[0] = d;
        pb_k[0] = '1;
        send_pkt(1, 32'h0000_0001, 6'h22);
        drain_and_compare("t4_wrap");

        // 5: 20 random back-to-back packets with random backpressure.
        pulse_reset();
        rdy_rand = 1'b1;
        for (int p = 0; p < 20; p++) begin
            nb = $urandom_range(0, 4);
            sum = 0;
            for (int i = 0; i < nb; i++) begin
                for (int w = 0; w < NW; w++) pb_d[i][32*w +: 32] = $urandom;
                pb_k[i] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
                sum = sum + model_sum(pb_d[i], pb_k[i]);
            end
            send_pkt(nb, ($urandom_range(0, 1) == 1) ? sum : $urandom, 6'($urandom));
        end
        drain_and_compare("t5_random");
        check("t5_pkt_cnt_20", 640'(pkt_cnt), 640'(20));
        rdy_rand = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // 6: reset after the second payload beat of a packet.
        d = '0;
        d[31:0] = 32'hDEAD_BEEF;
        send_beat(d, '1, 6'h07, 1'b0);
        send_beat(d, '1, 6'h07, 1'b0);
        pulse_reset();
        repeat (6) @(posedge aclk);
        #1;
        check("t6_no_beats_after_reset", 640'(obs_beats.size()), 640'(0));
        check("t6_no_status", 640'(obs_stat.size()), 640'(0));
        check("t6_counters_cleared", 640'({pkt_cnt, err_cnt}), 640'(0));
        d = '0;
        d[31:0] = 32'h0000_1111;
        pb_d[0] = d;
        pb_k[0] = '1;
        pb_d[1] = d;
        pb_k[1] = '1;
        send_pkt(2, 32'h0000_2222, 6'h09);
        drain_and_compare("t6_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
